// File: rtl/fpow_seq_if.sv
// fpow_seq_if: front-end request/response and shared-multiplier signals of fpow_seq.
interface fpow_seq_if #(parameter int EXP_W = 8);
  logic start, busy, done;
  logic [31:0] base, result, mul_a, mul_b, mul_c;
  logic [EXP_W-1:0] exp;
  modport master(output start, base, exp, mul_c, input busy, done, result, mul_a, mul_b);
  modport slave(input start, base, exp, mul_c, output busy, done, result, mul_a, mul_b);
endinterface

// File: rtl/fpow_seq.sv
// fpow_seq: square-and-multiply float power sequencer for a 1-cycle external multiplier.
// Optional zero/denormal-base shortcut enabled by defining FPOW_ZERO_BYPASS_EN.
module fpow_seq #(parameter int EXP_W = 8) (
  input logic clk,
  input logic rst,
  fpow_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, MUL_ACC, CAP_ACC, SHIFT, MUL_SQ, CAP_SQ, DONE} state_t;
  state_t state, nxt;
  logic [31:0] acc, sq;
  logic [EXP_W-1:0] e;
  logic sgn, byp;
`ifdef FPOW_ZERO_BYPASS_EN
  logic zb;
  always_ff @(posedge clk or posedge rst)
    if (rst) zb <= 1'b0;
    else if (state == IDLE && bus.start) zb <= bus.base[30:23] == 8'h00;
  assign byp = state == CHECK && zb && e != '0;
`else
  assign byp = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? CHECK : IDLE;
      CHECK:   nxt = (e == '0 || byp) ? DONE : e[0] ? MUL_ACC : SHIFT;
      MUL_ACC: nxt = CAP_ACC;
      CAP_ACC: nxt = SHIFT;
      SHIFT:   nxt = (e >> 1) != '0 ? MUL_SQ : DONE;
      MUL_SQ:  nxt = CAP_SQ;
      CAP_SQ:  nxt = CHECK;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.mul_a = state == MUL_ACC ? acc : state == MUL_SQ ? sq : 32'h0;
    bus.mul_b = (state == MUL_ACC || state == MUL_SQ) ? sq : 32'h0;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // the multiplier never sees a sign, so the sign is reapplied only when the result is latched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sq <= '0;
      e <= '0;
      sgn <= 1'b0;
      bus.result <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        acc <= 32'h3F800000;
        sq <= {1'b0, bus.base[30:0]};
        e <= bus.exp;
        sgn <= bus.base[31] & bus.exp[0];
      end
      if (state == CAP_ACC) acc <= bus.mul_c;
      if (state == CAP_SQ) sq <= bus.mul_c;
      if (state == SHIFT) e <= e >> 1;
      if (nxt == DONE) bus.result <= byp ? {sgn, 31'b0} : {sgn, acc[30:0]};
    end
  end
endmodule

// File: tb/tb_fpow_seq.sv
// tb_fpow_seq: randomized + directed scoreboard bench for fpow_seq with a behavioural multiplier.
module tb_fpow_seq;
  typedef struct {logic [31:0] res; int cyc;} exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, vectors = 0, miscompares = 0, c0;
  bit prev_op = 0;
  exp_t exp_q[$];
  logic [63:0] op_q[$];
  fpow_seq_if #(8) bus();
  fpow_seq #(.EXP_W(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0] ex;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ex = a[30:23] + b[30:23] - 8'd127;
    return p[47] ? {1'b0, ex + 8'd1, p[46:24]} : {1'b0, ex, p[45:23]};
  endfunction
  always @(posedge clk) bus.mul_c <= fmul(bus.mul_a, bus.mul_b);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask
  // mathematical square-and-multiply over exponent bits, with the external multiplier's arithmetic
  task automatic model(input logic [31:0] b, input logic [7:0] ex, output logic [31:0] res, output int n);
    logic [31:0] r, s;
    logic [7:0] x;
    int m;
    r = 32'h3F800000;
    s = {1'b0, b[30:0]};
    x = ex;
    m = 0;
    for (int i = 0; i < 8; i++) if (ex[i]) m = i + 1;
    n = ex == 0 ? 2 : 4 * m + 2 * $countones(ex) - 1;
`ifdef FPOW_ZERO_BYPASS_EN
    if (b[30:23] == 0 && ex != 0) begin
      res = {b[31] & ex[0], 31'b0};
      n = 2;
      return;
    end
`endif
    while (x != 0) begin
      if (x[0]) begin
        op_q.push_back({r, s});
        r = fmul(r, s);
      end
      x = x >> 1;
      if (x != 0) begin
        op_q.push_back({s, s});
        s = fmul(s, s);
      end
    end
    res = {b[31] & ex[0], r[30:0]};
  endtask
  task automatic launch(input logic [31:0] b, input logic [7:0] ex, input logic [31:0] want, input bit use_want, output int n);
    logic [31:0] res;
    @(posedge clk);
    #1;
    bus.start = 1;
    bus.base = b;
    bus.exp = ex;
    c0 = cyc;
    model(b, ex, res, n);
    exp_q.push_back('{use_want ? want : res, c0 + n});
    @(posedge clk);
    #1;
    bus.start = 0;
  endtask
  task automatic run(input logic [31:0] b, input logic [7:0] ex, input logic [31:0] want, input bit use_want);
    int n, nb, t;
    launch(b, ex, want, use_want, n);
    nb = 0;
    t = 0;
    while (bus.busy && t < 200) begin
      nb++;
      t++;
      @(posedge clk);
      #1;
    end
    chk("busy_len", nb, n);
  endtask
  always @(negedge clk) begin
    if (rst) prev_op <= 0;
    else begin
      if (bus.mul_a != 0 || bus.mul_b != 0) begin
        chk("no_back_to_back", {31'b0, prev_op}, 0);
        if (op_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_op: got %h,%h want none", bus.mul_a, bus.mul_b);
        end else chk("op_pair", bus.mul_a ^ {bus.mul_b[15:0], bus.mul_b[31:16]}, op_q[0][63:32] ^ {op_q[0][15:0], op_q[0][31:16]});
        if (op_q.size() != 0) chk("op_b", bus.mul_b, op_q.pop_front()[31:0]);
        prev_op <= 1;
      end else prev_op <= 0;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got result %h want no done", bus.result);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("result", bus.result, x.res);
          chk("done_cycle", cyc, x.cyc);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.start = 0;
    bus.base = 0;
    bus.exp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    rst = 0;
    run(32'h40000000, 8'd10, 32'h44800000, 1);
    run(32'hBFC00000, 8'd3, 32'hC0580000, 1);
    run(32'hC0400000, 8'd0, 32'h3F800000, 1);
    run(32'h3FC00000, 8'd1, 32'h3FC00000, 1);
    run(32'h3F800000, 8'd255, 32'h3F800000, 1);
`ifdef FPOW_ZERO_BYPASS_EN
    run(32'h00000000, 8'd5, 32'h00000000, 1);
    run(32'h80000000, 8'd5, 32'h80000000, 1);
`endif
    for (int i = 0; i < 25; i++) begin
      logic [31:0] b;
      b = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
      run(b, 8'($urandom), 32'h0, 0);
    end
    launch(32'h3FC00000, 8'd200, 32'h0, 0, n);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1;
    bus.base = 32'h40400000;
    bus.exp = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrun_busy", bus.busy, 1);
    rst = 1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    exp_q.delete();
    op_q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    run(32'h3FC00000, 8'd1, 32'h3FC00000, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("op_q_drained", op_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fpow_seq.md
# fpow_seq

Sequencer computing `base^exp` for a single-precision float `base` and an unsigned integer `exp`. It uses square-and-multiply. The block drives one external pipelined float multiplier, which has a 1-cycle registered output, no sign handling and no special-value handling. It owns the operand muxing, the iteration over exponent bits and the sign fix-up, and it sits between the power-function front end and the shared multiplier instance.

## Interface
- `EXP_W`, default 8: width of the integer exponent.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `base` in 32: IEEE-754 single. Captured when `start` is accepted.
- `exp` in EXP_W: unsigned exponent. Captured when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse. `result` is valid while it is high.
- `result` out 32: final value. Holds until the next `done`.
- `mul_a` out 32: multiplier operand A.
- `mul_b` out 32: multiplier operand B.
- `mul_c` in 32: multiplier product. Valid one cycle after the operands are presented. Sign bit is always 0.

## Operation
- Internal registers:
  - `acc` (32), set to 0x3F800000 (1.0) on start.
  - `sq` (32), set to `{1'b0, base[30:0]}` on start.
  - `e` (EXP_W), set to `exp` on start.
  - `sgn`, set to `base[31] & exp[0]`.
  - `zb`, set to `base[30:23]==0`.
- States and transitions:
  - IDLE: if `start`, load the registers and go to CHECK. Otherwise stay.
  - CHECK:
    - if `e==0`, go to DONE;
    - else if `e[0]`, go to MUL_ACC;
    - else go to SHIFT.
  - MUL_ACC: drive `mul_a=acc`, `mul_b=sq`. Go to CAP_ACC.
  - CAP_ACC: `acc <= mul_c`. Go to SHIFT.
  - SHIFT: `e <= e>>1`. If `(e>>1)!=0`, go to MUL_SQ. Otherwise go to DONE.
  - MUL_SQ: drive `mul_a=sq`, `mul_b=sq`. Go to CAP_SQ.
  - CAP_SQ: `sq <= mul_c`. Go to CHECK.
  - DONE: `done=1`. Go to IDLE.
- On every edge entering DONE, load `result <= {sgn, acc[30:0]}`.
  - Case `exp==0`: this gives 0x3F800000, or 0xBF800000 never, because `sgn` is 0 when `exp` is even.
- `mul_a` and `mul_b` are combinational from state. They are 0x00000000 outside MUL_ACC and MUL_SQ.
- `start` while `busy` is ignored and has no effect on the captured operands.
- No rounding, overflow or NaN handling beyond what the multiplier provides. Exponent-field overflow wraps exactly as the multiplier's 8-bit arithmetic does.

## Timing
- Reset values:
  - state IDLE;
  - `busy`=0, `done`=0, `result`=0x00000000;
  - `mul_a`=`mul_b`=0;
  - `acc`, `sq`, `e`, `sgn`, `zb` all 0.
- Reset mid-operation aborts immediately to IDLE. No `done` is produced. `result` returns to 0.
- Latency definitions:
  - m = bit length of `exp`;
  - k = popcount of `exp`;
  - cycle C0 is the cycle in which `start` is accepted.
- `done` is high in cycle C0+N:
  - N = 4m+2k-1 for `exp`≠0;
  - N = 2 for `exp`=0.
- Worst case, EXP_W=8 and `exp`=255: N=47.
- `busy` is high from C0+1 through C0+N inclusive.
- A new `start` is accepted in cycle C0+N+1 at the earliest.
- Each multiply occupies exactly 2 cycles: operand cycle, then capture cycle. The multiplier is never given back-to-back operands.

## Configuration
- `FPOW_ZERO_BYPASS_EN` defined:
  - in CHECK, if `zb`=1 and `e`≠0, go straight to DONE with `result <= {sgn, 31'b0}`;
  - N=2;
  - no multiplier operands are issued.
- `FPOW_ZERO_BYPASS_EN` undefined:
  - `zb` is not implemented;
  - zero or denormal bases go through the normal loop;
  - the result is whatever the multiplier produces and is unspecified.

## Test plan
- `base`=0x40000000 (2.0), `exp`=10 → `result`=0x44800000 (1024.0), `done` at C0+19, `busy` high C0+1..C0+19.
- `base`=0xBFC00000 (-1.5), `exp`=3 → `result`=0xC0580000 (-3.375), `done` at C0+11. Also check `mul_a`/`mul_b` sequence: (1.0,1.5), (1.5,1.5), (1.5,2.25).
- `base`=0xC0400000 (-3.0), `exp`=0 → `result`=0x3F800000, `done` at C0+2, no nonzero `mul_a`/`mul_b` observed.
- `base`=0x00000000, `exp`=5, macro defined → `result`=0x00000000, `done` at C0+2. Same with `base`=0x80000000 → `result`=0x80000000.
- Reset and busy handling:
  - start `base`=0x3FC00000, `exp`=200;
  - pulse `start` with other operands at C0+5 → ignored;
  - assert `rst` at C0+12 → immediate IDLE, `busy`=0, `result`=0, no `done`;
  - restart with `exp`=1 → `result`=0x3FC00000 at C0'+5.
